// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle between hazard detection / fetch and the IF/ID stall controller.
// No latency of its own; carries both the stall requests and the controller status.
// No handshake: stall inputs are level requests that are honoured on every edge.
interface pipeline_stall_ctrl_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic              Stall_PC;
  logic              Stall_ID;
  logic              Stall_ID_EX;
  logic              Branch_Taken;
  logic [31:0]       IF_Instruction;
  logic [31:0]       IF_PCPlus4;
  logic [CTRL_W-1:0] ID_ControlIn;

  logic              PC_WriteEn;
  logic [31:0]       ID_Instruction;
  logic [31:0]       ID_PCPlus4;
  logic              ID_Valid;
  logic [CTRL_W-1:0] EX_ControlOut;
  logic [CNT_W-1:0]  Stall_Count;
  logic [CNT_W-1:0]  Flush_Count;
  logic              Stall_Timeout;
  logic              Protocol_Err;
  logic [1:0]        State;

  // Hazard unit / fetch side: drives requests, observes status.
  modport master (
    output Stall_PC, Stall_ID, Stall_ID_EX, Branch_Taken,
           IF_Instruction, IF_PCPlus4, ID_ControlIn,
    input  PC_WriteEn, ID_Instruction, ID_PCPlus4, ID_Valid, EX_ControlOut,
           Stall_Count, Flush_Count, Stall_Timeout, Protocol_Err, State
  );

  // Stall controller side.
  modport slave (
    input  Stall_PC, Stall_ID, Stall_ID_EX, Branch_Taken,
           IF_Instruction, IF_PCPlus4, ID_ControlIn,
    output PC_WriteEn, ID_Instruction, ID_PCPlus4, ID_Valid, EX_ControlOut,
           Stall_Count, Flush_Count, Stall_Timeout, Protocol_Err, State
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// IF/ID register owner: applies stall/flush requests, bubbles ID/EX control, tracks stats.
// Latency: one register stage IF->ID; PC_WriteEn and EX_ControlOut are combinational.
// Backpressure: Stall_PC/Stall_ID hold PC and IF/ID; Branch_Taken always wins and squashes.
module pipeline_stall_ctrl #(
  parameter int CTRL_W    = 16,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  pipeline_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [31:0]       id_pc4_q, id_pc4_d;
  logic              id_valid_q, id_valid_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;
  logic              proto_err_q, proto_err_d;

  logic any_stall;
  logic bubble;
  logic stall_run;

  // Request decode and the combinational PC enable / ID-EX bubble mux.
  always_comb begin
    any_stall = bus.Stall_PC | bus.Stall_ID | bus.Stall_ID_EX;
    bubble    = bus.Branch_Taken | bus.Stall_ID_EX;
    stall_run = any_stall & ~bus.Branch_Taken;
    bus.PC_WriteEn    = bus.Branch_Taken | ~bus.Stall_PC;
    bus.EX_ControlOut = bubble ? '0 : bus.ID_ControlIn;
  end

  // FSM next state: flush dominates, any stall request holds us in STALL.
  always_comb begin
    state_d = ST_RUN;
    unique case (state_q)
      ST_RUN, ST_STALL, ST_FLUSH: begin
        if (bus.Branch_Taken)  state_d = ST_FLUSH;
        else if (any_stall)    state_d = ST_STALL;
        else                   state_d = ST_RUN;
      end
      default:                 state_d = ST_RUN;
    endcase
  end

  // IF/ID next value: squash beats hold beats load.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (bus.Branch_Taken) begin
      id_instr_d = '0;
      id_pc4_d   = '0;
      id_valid_d = 1'b0;
    end else if (!bus.Stall_ID) begin
      id_instr_d = bus.IF_Instruction;
      id_pc4_d   = bus.IF_PCPlus4;
      id_valid_d = 1'b1;
    end
  end

  // Saturating stall-run tracker, perf counters and sticky error flags.
  always_comb begin
    run_cnt_d   = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;

    if (stall_run) begin
      run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
    end
    if (run_cnt_d == RUN_MAX) begin
      timeout_d = 1'b1;
    end

    if (bus.Stall_ID_EX && !bus.Branch_Taken && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (bus.Branch_Taken && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Inconsistent requests are still applied individually; we only flag them.
    if (!((bus.Stall_PC == bus.Stall_ID) && (bus.Stall_ID == bus.Stall_ID_EX))) begin
      proto_err_d = 1'b1;
    end
  end

  // State register; reset returns every output to its idle (NOP, RUN) value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_RUN;
      id_instr_q  <= '0;
      id_pc4_q    <= '0;
      id_valid_q  <= 1'b0;
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_instr_q  <= id_instr_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      run_cnt_q   <= run_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.ID_Instruction = id_instr_q;
    bus.ID_PCPlus4     = id_pc4_q;
    bus.ID_Valid       = id_valid_q;
    bus.Stall_Count    = stall_cnt_q;
    bus.Flush_Count    = flush_cnt_q;
    bus.Stall_Timeout  = timeout_q;
    bus.Protocol_Err   = proto_err_q;
    bus.State          = state_q;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default instance plus a CNT_W=4 instance for saturation.
module tb_pipeline_stall_ctrl;

  logic Clk;
  logic Rst_n;
  int   n_checks;
  int   n_fails;

  pipeline_stall_ctrl_if #(.CTRL_W(16), .CNT_W(16)) bus ();
  pipeline_stall_ctrl_if #(.CTRL_W(16), .CNT_W(4))  b4 ();

  pipeline_stall_ctrl #(.CTRL_W(16), .CNT_W(16), .MAX_STALL(8)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  pipeline_stall_ctrl #(.CTRL_W(16), .CNT_W(4), .MAX_STALL(8)) dut4 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (b4.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_stalls(input logic pc, input logic id, input logic idex, input logic br);
    bus.Stall_PC     = pc;
    bus.Stall_ID     = id;
    bus.Stall_ID_EX  = idex;
    bus.Branch_Taken = br;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    set_stalls(0, 0, 0, 0);
    bus.IF_Instruction = 32'h0; bus.IF_PCPlus4 = 32'h0; bus.ID_ControlIn = 16'h0;
    b4.Stall_PC = 0; b4.Stall_ID = 0; b4.Stall_ID_EX = 0; b4.Branch_Taken = 0;
    b4.IF_Instruction = 32'h0; b4.IF_PCPlus4 = 32'h0; b4.ID_ControlIn = 16'h0;
    tick(); tick();
    n_checks++; if (bus.ID_Instruction !== 32'h0) begin n_fails++; $display("FAIL reset_instr got %h want 0", bus.ID_Instruction); end
    n_checks++; if (bus.ID_Valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", bus.ID_Valid); end
    n_checks++; if (bus.Stall_Count !== 16'd0 || bus.Flush_Count !== 16'd0) begin n_fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.Stall_Count, bus.Flush_Count); end
    n_checks++; if (bus.State !== 2'd0 || bus.Stall_Timeout !== 1'b0 || bus.Protocol_Err !== 1'b0) begin n_fails++; $display("FAIL reset_state got st=%0d to=%b pe=%b want 0/0/0", bus.State, bus.Stall_Timeout, bus.Protocol_Err); end
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
  endtask

  task automatic test_run();
    set_stalls(0, 0, 0, 0);
    bus.IF_Instruction = 32'h20080005; bus.IF_PCPlus4 = 32'h4; bus.ID_ControlIn = 16'h1234;
    #1;
    n_checks++; if (bus.PC_WriteEn !== 1'b1) begin n_fails++; $display("FAIL run_pcwe got %b want 1", bus.PC_WriteEn); end
    n_checks++; if (bus.EX_ControlOut !== 16'h1234) begin n_fails++; $display("FAIL run_exctl got %h want 1234", bus.EX_ControlOut); end
    tick();
    n_checks++; if (bus.ID_Instruction !== 32'h20080005 || bus.ID_PCPlus4 !== 32'h4 || bus.ID_Valid !== 1'b1) begin n_fails++; $display("FAIL run_first got %h/%h/%b want 20080005/4/1", bus.ID_Instruction, bus.ID_PCPlus4, bus.ID_Valid); end
    bus.IF_Instruction = 32'h20090003; bus.IF_PCPlus4 = 32'h8;
    tick();
    n_checks++; if (bus.ID_Instruction !== 32'h20090003 || bus.ID_PCPlus4 !== 32'h8) begin n_fails++; $display("FAIL run_second got %h/%h want 20090003/8", bus.ID_Instruction, bus.ID_PCPlus4); end
    n_checks++; if (bus.Stall_Count !== 16'd0 || bus.Flush_Count !== 16'd0 || bus.State !== 2'd0) begin n_fails++; $display("FAIL run_counts got %0d/%0d st=%0d want 0/0/0", bus.Stall_Count, bus.Flush_Count, bus.State); end
  endtask

  task automatic test_stall();
    set_stalls(1, 1, 1, 0);
    bus.IF_Instruction = 32'hDEADBEEF; bus.IF_PCPlus4 = 32'hC; bus.ID_ControlIn = 16'hABCD;
    #1;
    n_checks++; if (bus.PC_WriteEn !== 1'b0) begin n_fails++; $display("FAIL stall_pcwe got %b want 0", bus.PC_WriteEn); end
    n_checks++; if (bus.EX_ControlOut !== 16'h0) begin n_fails++; $display("FAIL stall_bubble got %h want 0", bus.EX_ControlOut); end
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.ID_Instruction !== 32'h20090003 || bus.ID_PCPlus4 !== 32'h8 || bus.ID_Valid !== 1'b1) begin n_fails++; $display("FAIL stall_hold got %h/%h/%b want 20090003/8/1", bus.ID_Instruction, bus.ID_PCPlus4, bus.ID_Valid); end
    n_checks++; if (bus.Stall_Count !== 16'd3) begin n_fails++; $display("FAIL stall_count got %0d want 3", bus.Stall_Count); end
    n_checks++; if (bus.State !== 2'd1) begin n_fails++; $display("FAIL stall_state got %0d want 1", bus.State); end
    set_stalls(0, 0, 0, 0);
    #1;
    n_checks++; if (bus.EX_ControlOut !== 16'hABCD) begin n_fails++; $display("FAIL stall_release_ctl got %h want abcd", bus.EX_ControlOut); end
    tick();
    n_checks++; if (bus.State !== 2'd0 || bus.ID_Instruction !== 32'hDEADBEEF) begin n_fails++; $display("FAIL stall_release got st=%0d instr=%h want 0/deadbeef", bus.State, bus.ID_Instruction); end
  endtask

  task automatic test_flush();
    set_stalls(1, 1, 1, 1);
    bus.IF_Instruction = 32'h0BADF00D; bus.IF_PCPlus4 = 32'h10;
    #1;
    n_checks++; if (bus.PC_WriteEn !== 1'b1 || bus.EX_ControlOut !== 16'h0) begin n_fails++; $display("FAIL flush_comb got we=%b ctl=%h want 1/0", bus.PC_WriteEn, bus.EX_ControlOut); end
    tick();
    n_checks++; if (bus.ID_Instruction !== 32'h0 || bus.ID_PCPlus4 !== 32'h0 || bus.ID_Valid !== 1'b0) begin n_fails++; $display("FAIL flush_squash got %h/%h/%b want 0/0/0", bus.ID_Instruction, bus.ID_PCPlus4, bus.ID_Valid); end
    n_checks++; if (bus.Flush_Count !== 16'd1 || bus.Stall_Count !== 16'd3) begin n_fails++; $display("FAIL flush_counts got %0d/%0d want 1/3", bus.Flush_Count, bus.Stall_Count); end
    n_checks++; if (bus.State !== 2'd2) begin n_fails++; $display("FAIL flush_state got %0d want 2", bus.State); end
    set_stalls(0, 0, 0, 0);
    bus.IF_Instruction = 32'h11111111; bus.IF_PCPlus4 = 32'h14;
    tick();
    n_checks++; if (bus.State !== 2'd0 || bus.ID_Valid !== 1'b1 || bus.ID_Instruction !== 32'h11111111) begin n_fails++; $display("FAIL flush_after got st=%0d v=%b i=%h want 0/1/11111111", bus.State, bus.ID_Valid, bus.ID_Instruction); end
  endtask

  task automatic test_timeout();
    set_stalls(1, 1, 1, 0);
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (bus.Stall_Timeout !== 1'b0) begin n_fails++; $display("FAIL timeout_run7 got %b want 0", bus.Stall_Timeout); end
    set_stalls(0, 0, 0, 0);
    tick();
    set_stalls(1, 1, 1, 0);
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (bus.Stall_Timeout !== 1'b0) begin n_fails++; $display("FAIL timeout_edge7 got %b want 0", bus.Stall_Timeout); end
    tick();
    n_checks++; if (bus.Stall_Timeout !== 1'b1) begin n_fails++; $display("FAIL timeout_edge8 got %b want 1", bus.Stall_Timeout); end
    n_checks++; if (bus.Stall_Count !== 16'd18) begin n_fails++; $display("FAIL timeout_count got %0d want 18", bus.Stall_Count); end
    set_stalls(0, 0, 0, 0);
    tick(); tick();
    n_checks++; if (bus.Stall_Timeout !== 1'b1 || bus.State !== 2'd0) begin n_fails++; $display("FAIL timeout_sticky got to=%b st=%0d want 1/0", bus.Stall_Timeout, bus.State); end
  endtask

  task automatic test_protocol();
    n_checks++; if (bus.Protocol_Err !== 1'b0) begin n_fails++; $display("FAIL proto_before got %b want 0", bus.Protocol_Err); end
    set_stalls(1, 0, 0, 0);
    bus.IF_Instruction = 32'h12345678; bus.IF_PCPlus4 = 32'h20;
    #1;
    n_checks++; if (bus.PC_WriteEn !== 1'b0 || bus.EX_ControlOut !== 16'hABCD) begin n_fails++; $display("FAIL proto_comb got we=%b ctl=%h want 0/abcd", bus.PC_WriteEn, bus.EX_ControlOut); end
    tick();
    n_checks++; if (bus.Protocol_Err !== 1'b1) begin n_fails++; $display("FAIL proto_set got %b want 1", bus.Protocol_Err); end
    n_checks++; if (bus.ID_Instruction !== 32'h12345678 || bus.ID_Valid !== 1'b1 || bus.State !== 2'd1) begin n_fails++; $display("FAIL proto_load got %h/%b st=%0d want 12345678/1/1", bus.ID_Instruction, bus.ID_Valid, bus.State); end
    n_checks++; if (bus.Stall_Count !== 16'd18) begin n_fails++; $display("FAIL proto_count got %0d want 18", bus.Stall_Count); end
    set_stalls(0, 0, 0, 0);
    tick();
    n_checks++; if (bus.Protocol_Err !== 1'b1) begin n_fails++; $display("FAIL proto_sticky got %b want 1", bus.Protocol_Err); end
  endtask

  task automatic test_saturate_reset();
    b4.Stall_PC = 1; b4.Stall_ID = 1; b4.Stall_ID_EX = 1;
    set_stalls(1, 1, 1, 0);
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (b4.Stall_Count !== 4'd15) begin n_fails++; $display("FAIL sat_reach got %0d want 15", b4.Stall_Count); end
    tick(); tick();
    n_checks++; if (b4.Stall_Count !== 4'd15) begin n_fails++; $display("FAIL sat_hold got %0d want 15", b4.Stall_Count); end
    n_checks++; if (b4.Stall_Timeout !== 1'b1 || b4.State !== 2'd1) begin n_fails++; $display("FAIL sat_state got to=%b st=%0d want 1/1", b4.Stall_Timeout, b4.State); end
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++; if (b4.Stall_Count !== 4'd0 || b4.Stall_Timeout !== 1'b0 || b4.State !== 2'd0 || b4.ID_Valid !== 1'b0) begin n_fails++; $display("FAIL async_rst4 got c=%0d to=%b st=%0d v=%b want 0/0/0/0", b4.Stall_Count, b4.Stall_Timeout, b4.State, b4.ID_Valid); end
    n_checks++; if (bus.Protocol_Err !== 1'b0 || bus.Stall_Count !== 16'd0 || bus.ID_Instruction !== 32'h0) begin n_fails++; $display("FAIL async_rst got pe=%b c=%0d i=%h want 0/0/0", bus.Protocol_Err, bus.Stall_Count, bus.ID_Instruction); end
    @(negedge Clk);
    Rst_n = 1'b1;
    b4.Stall_PC = 0; b4.Stall_ID = 0; b4.Stall_ID_EX = 0;
    b4.IF_Instruction = 32'hCAFE0001; b4.IF_PCPlus4 = 32'h24;
    tick();
    n_checks++; if (b4.State !== 2'd0 || b4.ID_Valid !== 1'b1 || b4.ID_Instruction !== 32'hCAFE0001) begin n_fails++; $display("FAIL post_rst got st=%0d v=%b i=%h want 0/1/cafe0001", b4.State, b4.ID_Valid, b4.ID_Instruction); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_run();
    test_stall();
    test_flush();
    test_timeout();
    test_protocol();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
